// File: rtl/common_pkg.sv
// Shared constants for the PET CPU address map.
// CPU_ADDR_WIDTH sets the CPU address bus width. The remaining constants mark
// the region boundaries used by the address decoder.
package common_pkg;

  localparam int CPU_ADDR_WIDTH = 16;

  localparam logic [CPU_ADDR_WIDTH-1:0] RAM_TOP      = 16'h7FFF;
  localparam logic [CPU_ADDR_WIDTH-1:0] VRAM_BASE    = 16'h8000;
  localparam logic [CPU_ADDR_WIDTH-1:0] SID_BASE     = 16'h8F00;
  localparam logic [CPU_ADDR_WIDTH-1:0] ROM_BASE     = 16'h9000;
  localparam logic [CPU_ADDR_WIDTH-1:0] IO_BASE      = 16'hE800;
  localparam logic [CPU_ADDR_WIDTH-1:0] IO_TOP       = 16'hE8FF;
  localparam logic [CPU_ADDR_WIDTH-1:0] KERNAL_BASE  = 16'hF000;
  localparam logic [CPU_ADDR_WIDTH-1:0] CFG_REG_ADDR = 16'hFFF0;

  // Low-byte offsets inside the I/O page ($E8xx): upper bound (exclusive)
  // of each device window.
  localparam logic [7:0] MAGIC_END = 8'h10;
  localparam logic [7:0] PIA1_END  = 8'h20;
  localparam logic [7:0] PIA2_END  = 8'h40;
  localparam logic [7:0] VIA_END   = 8'h80;

  // Configuration register bit positions.
  localparam int CFG_SID_DIS = 0;
  localparam int CFG_UNMAP_RAM = 1;

endpackage

// File: rtl/address_decoding.sv
// PET CPU address decoder.
// Decodes the CPU address into exactly one target enable (RAM/ROM, magic
// register, PIA1, PIA2, VIA, CRTC, SID) plus region flags (io, vram, rom).
// All decode outputs are combinational from cpu_addr_i and the write-only
// configuration register cfg, which the CPU writes at CFG_REG_ADDR.
// Ports:
//   sys_clock_i, sys_reset_i   clock, synchronous active-high reset
//   cpu_be_i, cpu_wr_strobe_i  bus ownership and write strobe
//   cpu_data_i, cpu_addr_i     CPU write data and address
//   *_en_o                     one-hot target selects; io_en_o = pia1|pia2|via
//   is_vram_o, is_rom_o        display-RAM and read-only flags
module address_decoding
  import common_pkg::*;
(
  input  logic                      sys_clock_i,
  input  logic                      sys_reset_i,
  input  logic                      cpu_be_i,
  input  logic                      cpu_wr_strobe_i,
  input  logic [7:0]                cpu_data_i,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i,
  output logic                      ram_en_o,
  output logic                      magic_en_o,
  output logic                      pia1_en_o,
  output logic                      pia2_en_o,
  output logic                      via_en_o,
  output logic                      crtc_en_o,
  output logic                      sid_en_o,
  output logic                      io_en_o,
  output logic                      is_vram_o,
  output logic                      is_rom_o
);

  logic [7:0] cfg;
  logic       cfg_wr;

  assign cfg_wr = cpu_be_i && cpu_wr_strobe_i && (cpu_addr_i == CFG_REG_ADDR);

  // Reset wins over a write on the same edge.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      cfg <= 8'h00;
    end else if (cfg_wr) begin
      cfg <= cpu_data_i;
    end
  end

  // Priority chain on ascending region boundaries. cfg bits are only
  // consulted inside the two regions they modify, so the reset decode never
  // depends on anything but the address.
  always_comb begin
    ram_en_o   = 1'b0;
    magic_en_o = 1'b0;
    pia1_en_o  = 1'b0;
    pia2_en_o  = 1'b0;
    via_en_o   = 1'b0;
    crtc_en_o  = 1'b0;
    sid_en_o   = 1'b0;
    is_vram_o  = 1'b0;
    is_rom_o   = 1'b0;
    if (cpu_addr_i <= RAM_TOP) begin
      ram_en_o = 1'b1;
    end else if (cpu_addr_i < SID_BASE) begin
      ram_en_o  = 1'b1;
      is_vram_o = 1'b1;
    end else if (cpu_addr_i < ROM_BASE) begin
      if (cfg[CFG_SID_DIS]) begin
        ram_en_o  = 1'b1;
        is_vram_o = 1'b1;
      end else begin
        sid_en_o = 1'b1;
      end
    end else if (cpu_addr_i < IO_BASE) begin
      ram_en_o = 1'b1;
      is_rom_o = 1'b1;
    end else if (cpu_addr_i <= IO_TOP) begin
      if (cpu_addr_i[7:0] < MAGIC_END) begin
        magic_en_o = 1'b1;
      end else if (cpu_addr_i[7:0] < PIA1_END) begin
        pia1_en_o = 1'b1;
      end else if (cpu_addr_i[7:0] < PIA2_END) begin
        pia2_en_o = 1'b1;
      end else if (cpu_addr_i[7:0] < VIA_END) begin
        via_en_o = 1'b1;
      end else begin
        crtc_en_o = 1'b1;
      end
    end else if (cpu_addr_i < KERNAL_BASE) begin
      // Unmapped hole above the I/O page: ROM unless remapped as RAM.
      ram_en_o = 1'b1;
      is_rom_o = !cfg[CFG_UNMAP_RAM];
    end else begin
      ram_en_o = 1'b1;
      is_rom_o = 1'b1;
    end
  end

  assign io_en_o = pia1_en_o | pia2_en_o | via_en_o;

endmodule

// File: tb/tb_address_decoding.sv
// Self-checking bench for address_decoding: a range-table model predicts the
// output vector every cycle; directed literal checks pin key addresses.
module tb_address_decoding;

  // Output vector layout: {ram, magic, pia1, pia2, via, crtc, sid, io, vram, rom}
  localparam logic [9:0] B_RAM   = 10'b10_0000_0000;
  localparam logic [9:0] B_MAGIC = 10'b01_0000_0000;
  localparam logic [9:0] B_PIA1  = 10'b00_1000_0000;
  localparam logic [9:0] B_PIA2  = 10'b00_0100_0000;
  localparam logic [9:0] B_VIA   = 10'b00_0010_0000;
  localparam logic [9:0] B_CRTC  = 10'b00_0001_0000;
  localparam logic [9:0] B_SID   = 10'b00_0000_1000;
  localparam logic [9:0] B_IO    = 10'b00_0000_0100;
  localparam logic [9:0] B_VRAM  = 10'b00_0000_0010;
  localparam logic [9:0] B_ROM   = 10'b00_0000_0001;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [9:0]  bits;
  } rng_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        be  = 1'b0;
  logic        wr  = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [15:0] addr = 16'h0000;
  logic        ram_en, magic_en, pia1_en, pia2_en, via_en, crtc_en, sid_en;
  logic        io_en, is_vram, is_rom;
  logic [9:0]  got;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic        chk_en = 1'b0;
  logic [7:0]  m_cfg = 8'h00;
  rng_t        map [11];

  address_decoding dut (
    .sys_clock_i     (clk),
    .sys_reset_i     (rst),
    .cpu_be_i        (be),
    .cpu_wr_strobe_i (wr),
    .cpu_data_i      (data),
    .cpu_addr_i      (addr),
    .ram_en_o        (ram_en),
    .magic_en_o      (magic_en),
    .pia1_en_o       (pia1_en),
    .pia2_en_o       (pia2_en),
    .via_en_o        (via_en),
    .crtc_en_o       (crtc_en),
    .sid_en_o        (sid_en),
    .io_en_o         (io_en),
    .is_vram_o       (is_vram),
    .is_rom_o        (is_rom)
  );

  assign got = {ram_en, magic_en, pia1_en, pia2_en, via_en, crtc_en, sid_en,
                io_en, is_vram, is_rom};

  always #5 clk = ~clk;

  // Reference model: reset-state range table, then the two cfg overrides.
  function automatic logic [9:0] model(input logic [15:0] a, input logic [7:0] c);
    logic [9:0] r;
    r = 10'h000;
    foreach (map[i]) begin
      if (a >= map[i].lo && a <= map[i].hi) r = map[i].bits;
    end
    if (c[0] && a >= 16'h8F00 && a <= 16'h8FFF) r = B_RAM | B_VRAM;
    if (c[1] && a >= 16'hE900 && a <= 16'hEFFF) r = r & ~B_ROM;
    return r;
  endfunction

  // The configuration register as the CPU sees it.
  always @(posedge clk) begin
    if (rst) m_cfg <= 8'h00;
    else if (be && wr && addr == 16'hFFF0) m_cfg <= data;
  end

  // Every-cycle compare against the model plus structural properties.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [9:0] exp_v;
      exp_v = model(addr, m_cfg);
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL decode addr=%h cfg=%h got=%b exp=%b", addr, m_cfg, got, exp_v);
      end
      checks++;
      if ($countones(got[9:3]) != 1) begin
        failures++;
        $display("FAIL onehot addr=%h got=%b exp=exactly one target", addr, got[9:3]);
      end
      checks++;
      if (got[2] !== (got[7] | got[6] | got[5])) begin
        failures++;
        $display("FAIL io_en addr=%h got=%b exp=%b", addr, got[2], got[7] | got[6] | got[5]);
      end
    end
  end

  task automatic check_lit(input string name, input logic [9:0] act, input logic [9:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, act, exp_v);
    end
  endtask

  task automatic probe(input string name, input logic [15:0] a, input logic [9:0] exp_v);
    addr = a;
    #1;
    check_lit(name, got, exp_v);
  endtask

  task automatic cpu_write(input logic b, input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    be = b; wr = 1'b1; addr = a; data = d;
    @(posedge clk); #1;
    be = 1'b0; wr = 1'b0; data = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    map[0]  = '{16'h0000, 16'h7FFF, B_RAM};
    map[1]  = '{16'h8000, 16'h8EFF, B_RAM | B_VRAM};
    map[2]  = '{16'h8F00, 16'h8FFF, B_SID};
    map[3]  = '{16'h9000, 16'hE7FF, B_RAM | B_ROM};
    map[4]  = '{16'hE800, 16'hE80F, B_MAGIC};
    map[5]  = '{16'hE810, 16'hE81F, B_PIA1 | B_IO};
    map[6]  = '{16'hE820, 16'hE83F, B_PIA2 | B_IO};
    map[7]  = '{16'hE840, 16'hE87F, B_VIA | B_IO};
    map[8]  = '{16'hE880, 16'hE8FF, B_CRTC};
    map[9]  = '{16'hE900, 16'hEFFF, B_RAM | B_ROM};
    map[10] = '{16'hF000, 16'hFFFF, B_RAM | B_ROM};

    // Pin the model to hand-derived values.
    check_lit("model_e810", model(16'hE810, 8'h00), B_PIA1 | B_IO);
    check_lit("model_8f00_sidoff", model(16'h8F00, 8'h01), B_RAM | B_VRAM);
    check_lit("model_e900_ram", model(16'hE900, 8'h02), B_RAM);

    // Reset with a concurrent write attempt to the config address.
    rst = 1'b1; be = 1'b1; wr = 1'b1; addr = 16'hFFF0; data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; be = 1'b0; wr = 1'b0;
    chk_en = 1'b1;
    probe("rst_0000", 16'h0000, B_RAM);
    probe("rst_8f00_sid", 16'h8F00, B_SID);
    probe("rst_e880_crtc", 16'hE880, B_CRTC);
    probe("rst_fff0_rom", 16'hFFF0, B_RAM | B_ROM);

    // Full sweep, one address per cycle.
    for (logic [16:0] a = 17'h0; a < 17'h10000; a++) begin
      @(posedge clk); #1;
      addr = a[15:0];
    end

    // SID disable.
    cpu_write(1'b1, 16'hFFF0, 8'h01);
    probe("cfg1_8f00", 16'h8F00, B_RAM | B_VRAM);
    probe("cfg1_8eff", 16'h8EFF, B_RAM | B_VRAM);
    probe("cfg1_e900", 16'hE900, B_RAM | B_ROM);

    // Unmapped-as-RAM (cfg[0] cleared again).
    cpu_write(1'b1, 16'hFFF0, 8'h02);
    probe("cfg2_e900", 16'hE900, B_RAM);
    probe("cfg2_efff", 16'hEFFF, B_RAM);
    probe("cfg2_f000", 16'hF000, B_RAM | B_ROM);
    probe("cfg2_8f00", 16'h8F00, B_SID);

    // Ignored writes after reset.
    do_reset();
    cpu_write(1'b0, 16'hFFF0, 8'h03);
    probe("nobe_8f00", 16'h8F00, B_SID);
    cpu_write(1'b1, 16'hFFF1, 8'h03);
    probe("badaddr_8f00", 16'h8F00, B_SID);
    probe("badaddr_e900", 16'hE900, B_RAM | B_ROM);

    // Reset beats a simultaneous write.
    cpu_write(1'b1, 16'hFFF0, 8'h03);
    @(posedge clk); #1;
    rst = 1'b1; be = 1'b1; wr = 1'b1; addr = 16'hFFF0; data = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0; be = 1'b0; wr = 1'b0;
    probe("rstwr_8f00", 16'h8F00, B_SID);
    probe("rstwr_e900", 16'hE900, B_RAM | B_ROM);

    // Randomized traffic biased toward the interesting regions.
    for (int i = 0; i < 4000; i++) begin
      int unsigned sel;
      @(posedge clk); #1;
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    addr = 16'(16'h8E80 + $urandom_range(0, 16'h1FF));
        2, 3:    addr = 16'(16'hE7F0 + $urandom_range(0, 16'h120));
        4:       addr = 16'(16'hEF00 + $urandom_range(0, 16'h1FF));
        5:       addr = 16'hFFF0 + 16'($urandom_range(0, 1));
        default: addr = 16'($urandom);
      endcase
      be   = ($urandom_range(0, 3) != 0);
      wr   = ($urandom_range(0, 7) == 0);
      data = 8'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; be = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/address_decoding.md
# address_decoding

Combinational CPU address decoder for the PET memory map, with one small clocked configuration register. It sits between the CPU bus interface and the RAM/ROM, I/O chip and SID select logic. It asserts exactly one target enable per CPU address and flags video-RAM and read-only regions.

## Interface
Parameters:
- none. `CPU_ADDR_WIDTH` (16) comes from `common_pkg`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `sys_clock_i`  in  1  system clock.
- `sys_reset_i`  in  1  synchronous, active-high reset.
- `cpu_be_i`  in  1  CPU bus enable; the CPU owns the bus this cycle.
- `cpu_wr_strobe_i`  in  1  single-cycle CPU write strobe.
- `cpu_data_i`  in  8  CPU write data.
- `cpu_addr_i`  in  `CPU_ADDR_WIDTH`  CPU address.
- `ram_en_o`  out  1  RAM/ROM select.
- `magic_en_o`  out  1  magic register select.
- `pia1_en_o`  out  1  PIA1 select.
- `pia2_en_o`  out  1  PIA2 select.
- `via_en_o`  out  1  VIA select.
- `crtc_en_o`  out  1  CRTC select.
- `sid_en_o`  out  1  SID select.
- `io_en_o`  out  1  high for a PIA1, PIA2 or VIA access.
- `is_vram_o`  out  1  address lies in display RAM.
- `is_rom_o`  out  1  address is read-only; RAM writes must be suppressed.

## Operation
Decode with `cfg` = 0 (the reset state), inclusive ranges:
- $0000-$7FFF: `ram_en`.
- $8000-$8EFF: `ram_en`, `is_vram`.
- $8F00-$8FFF: `sid_en` only.
- $9000-$E7FF: `ram_en`, `is_rom`.
- $E800-$E80F: `magic_en`.
- $E810-$E81F: `pia1_en`, `io_en`.
- $E820-$E83F: `pia2_en`, `io_en`.
- $E840-$E87F: `via_en`, `io_en`.
- $E880-$E8FF: `crtc_en` only. `io_en` stays 0.
- $E900-$EFFF (unmapped): `ram_en`, `is_rom`.
- $F000-$FFFF: `ram_en`, `is_rom`.
- Every output not listed for a range is 0.
- Exactly one of `ram`/`magic`/`pia1`/`pia2`/`via`/`crtc`/`sid` is high for every address.

Configuration register `cfg[7:0]`:
- Written when `cpu_be_i & cpu_wr_strobe_i` and `cpu_addr_i == $FFF0`; captures `cpu_data_i`.
- Write-only. Reads of $FFF0 return ROM.
- `cfg[0]` (SID disable): $8F00-$8FFF decodes as display RAM, i.e. `ram_en=1`, `is_vram=1`, `sid_en=0`.
- `cfg[1]` (unmapped-as-RAM): $E900-$EFFF has `is_rom=0`. `ram_en` remains 1.
- `cfg[7:2]`: stored, no effect.

## Timing
- All outputs are combinational from `cpu_addr_i` and `cfg`. Zero-cycle latency; no clock is needed for decode.
- `cfg` resets to $00 on any `sys_clock_i` edge where `sys_reset_i`=1. Reset takes priority over a simultaneous write.
- A write takes effect on the edge where the strobe is sampled. Decode reflects the new value from the following cycle.
- A strobe without `cpu_be_i`, or at any address other than $FFF0, leaves `cfg` unchanged.
- Strobe assertions spanning several cycles rewrite the same value; this is harmless.
- Undriven clocked inputs (X/Z) must not corrupt the reset-state decode. Decode paths must not depend on them while `cfg`=0.

## Structure
- `common_pkg` owns `CPU_ADDR_WIDTH` and the region base/limit constants: `RAM_TOP`, `VRAM_BASE`, `SID_BASE`, `ROM_BASE`, `IO_BASE`, `CFG_REG_ADDR`.
- Single module, no sub-modules. The `cfg` register is one `always_ff` block; decode is one `always_comb` priority chain on the upper address bits.

## Test plan
- Reset, then sweep $0000-$FFFF with a 17-bit loop counter. Every address must match the reset-state range list above, including the boundaries $7FFF/$8000, $8EFF/$8F00, $8FFF/$9000, $E7FF/$E800, $E80F/$E810, $E81F/$E820, $E83F/$E840, $E87F/$E880, $E8FF/$E900 and $EFFF/$F000.
- Write $01 to $FFF0 with `cpu_be_i`=1. Then $8F00 → `ram_en=1`, `is_vram=1`, `sid_en=0`, and $8EFF is unchanged.
- Write $02 to $FFF0. Then $E900 → `ram_en=1`, `is_rom=0`, and $F000 still has `is_rom=1`.
- Write $03 with `cpu_be_i`=0, or write $03 to $FFF1. `cfg` stays at its previous value; $8F00 still gives `sid_en=1` after reset.
- Assert `sys_reset_i` and a write of $FF to $FFF0 on the same edge. `cfg`=0, so $8F00 → `sid_en=1`.
- Check the one-hot property across the full sweep. `io_en` equals `pia1|pia2|via` everywhere and is 0 at $E880.
